ysyx_22041461_sram_arb: RTL and testbench
=========================================

YSYX_22041461_SRAM_ARB -- requirements
Module: ysyx_22041461_SRAM_ARB

Interface
REQ-001 SHALL have parameter Bits, 128, SRAM word width in bits.
REQ-002 SHALL have parameter Add_Width, 6, SRAM address width.
REQ-003 SHALL use one clock and an asynchronous, active-low reset, with the ports below; m0_/m1_ lines each denote one port per requester.
REQ-004 CLK  input  1  clock; all state updates on the rising edge.
REQ-005 RST_N  input  1  asynchronous active-low reset.
REQ-006 m0_req_valid/m1_req_valid  input  1  request pending.
REQ-007 m0_req_ready/m1_req_ready  output  1  request accepted this cycle.
REQ-008 m0_req_wen/m1_req_wen  input  1  1=write, 0=read.
REQ-009 m0_req_addr/m1_req_addr  input  Add_Width  word address.
REQ-010 m0_req_wdata/m1_req_wdata  input  Bits  write data.
REQ-011 m0_req_wmask/m1_req_wmask  input  Bits  per-bit write enable, 1=write bit.
REQ-012 m0_resp_valid/m1_resp_valid  output  1  response available.
REQ-013 m0_resp_ready/m1_resp_ready  input  1  response consumed.
REQ-014 m0_resp_rdata/m1_resp_rdata  output  Bits  read data; 0 for write responses.
REQ-015 sram_CEN  output  1  SRAM chip enable, active low.
REQ-016 sram_WEN  output  1  SRAM write enable, active low.
REQ-017 sram_BWEN  output  Bits  SRAM bit write enable, active low.
REQ-018 sram_A  output  Add_Width  SRAM address.
REQ-019 sram_D  output  Bits  SRAM write data.
REQ-020 sram_Q  input  Bits  SRAM read data; valid in the cycle after the access edge.

Function
REQ-021 SHALL implement FSM IDLE -> ACCESS -> CAPTURE -> RESP -> IDLE; one transaction in flight.
REQ-022 IDLE: mN_req_ready = mN_req_valid AND grant==N, combinationally; at most one ready high per cycle; both readies are 0 outside IDLE.
REQ-023 Arbitration: only one valid -> that requester wins; both valid -> requester other than last_grant wins (round-robin).
REQ-024 Handshake edge: latch owner, wen, addr, wdata and wmask; update last_grant; go to ACCESS.
REQ-025 ACCESS: sram_CEN=0, sram_A=addr, sram_D=wdata, sram_WEN=~wen, sram_BWEN=~wmask for writes and all-ones for reads, all from registers; next state CAPTURE.
REQ-026 Outside ACCESS: sram_CEN=1, sram_WEN=1, sram_BWEN all-ones, sram_A=0, sram_D=0.
REQ-027 CAPTURE: latch sram_Q into the response buffer for reads, 0 for writes; go to RESP.
REQ-028 RESP: owner's resp_valid=1 with buffer on resp_rdata, held stable until its resp_ready=1; the non-owner's resp_valid=0.
REQ-029 RESP with owner resp_ready=1: go to IDLE; the next grant is possible in that IDLE cycle.
REQ-030 Latency: handshake in cycle T -> resp_valid in cycle T+3; minimum interval between handshakes is 4 cycles.
REQ-031 resp_ready from a non-owner, or asserted outside RESP, SHALL be ignored.
REQ-032 Changes on request inputs after the handshake SHALL NOT affect the in-flight transaction.
REQ-033 Any address 0..2^Add_Width-1 is legal; there is no wrap or range check.

Reset
REQ-034 RST_N=0 SHALL immediately force state IDLE, last_grant=1, response buffer 0, both req_ready and resp_valid 0, sram_CEN=1, sram_WEN=1, sram_BWEN all-ones, sram_A=0, sram_D=0.
REQ-035 Reset mid-transaction SHALL drop the transaction with no response; a write whose ACCESS edge did not occur SHALL NOT reach the SRAM.

Verification
REQ-036 Single write, then read: m0 write addr 5, wdata 0xA5..A5, wmask all-ones -> sram_CEN=0 and sram_WEN=0 for exactly one cycle, and m0_resp_valid at T+3 with rdata 0; m0 read addr 5 -> rdata 0xA5..A5 at T+3.
REQ-037 Partial write: addr 5 holds 0xA5..A5; write wdata 0, wmask low 8 bits set -> sram_BWEN=~0xFF; a read returns 0xA5..A500.
REQ-038 Contention: both requesters valid continuously after reset -> grants m0, m1, m0, m1; each response is routed only to its owner.
REQ-039 Backpressure: hold m1_resp_ready=0 for 5 cycles in RESP -> m1_resp_valid and rdata stay stable; m0_req_ready stays 0; IDLE is reached one edge after ready rises.
REQ-040 Reset during ACCESS of a write to addr 9 -> all outputs at reset values, no resp_valid; a later read of addr 9 returns its prior contents.

Source files
------------

// File: rtl/ysyx_22041461_sram_arb.sv
// Round-robin arbiter that lets two requesters share one single-port SRAM.
// Only one transaction is in flight at a time: IDLE -> ACCESS -> CAPTURE -> RESP.
module ysyx_22041461_sram_arb #(
  parameter int Bits      = 128,
  parameter int Add_Width = 6
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 m0_req_valid,
  output logic                 m0_req_ready,
  input  logic                 m0_req_wen,
  input  logic [Add_Width-1:0] m0_req_addr,
  input  logic [Bits-1:0]      m0_req_wdata,
  input  logic [Bits-1:0]      m0_req_wmask,
  output logic                 m0_resp_valid,
  input  logic                 m0_resp_ready,
  output logic [Bits-1:0]      m0_resp_rdata,
  input  logic                 m1_req_valid,
  output logic                 m1_req_ready,
  input  logic                 m1_req_wen,
  input  logic [Add_Width-1:0] m1_req_addr,
  input  logic [Bits-1:0]      m1_req_wdata,
  input  logic [Bits-1:0]      m1_req_wmask,
  output logic                 m1_resp_valid,
  input  logic                 m1_resp_ready,
  output logic [Bits-1:0]      m1_resp_rdata,
  output logic                 sram_CEN,
  output logic                 sram_WEN,
  output logic [Bits-1:0]      sram_BWEN,
  output logic [Add_Width-1:0] sram_A,
  output logic [Bits-1:0]      sram_D,
  input  logic [Bits-1:0]      sram_Q
);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_e;

  state_e               state_q;
  logic                 last_grant_q;
  logic                 owner_q;
  logic                 wen_q;
  logic [Bits-1:0]      rdata_q;
  logic [1:0]           resp_valid_q;
  logic                 sram_cen_q;
  logic                 sram_wen_q;
  logic [Bits-1:0]      sram_bwen_q;
  logic [Add_Width-1:0] sram_a_q;
  logic [Bits-1:0]      sram_d_q;

  logic                 grant;
  logic                 handshake;
  logic                 owner_resp_ready;
  logic                 sel_wen;
  logic [Add_Width-1:0] sel_addr;
  logic [Bits-1:0]      sel_wdata;
  logic [Bits-1:0]      sel_wmask;

  // With both requesters pending, the one that did not win last time goes next.
  always_comb begin
    grant = ~last_grant_q;
    if (m0_req_valid && !m1_req_valid) grant = 1'b0;
    else if (!m0_req_valid && m1_req_valid) grant = 1'b1;
  end

  assign handshake = RST_N && (state_q == IDLE) && (m0_req_valid || m1_req_valid);
  assign m0_req_ready = handshake && !grant;
  assign m1_req_ready = handshake && grant;

  always_comb begin
    sel_wen   = m0_req_wen;
    sel_addr  = m0_req_addr;
    sel_wdata = m0_req_wdata;
    sel_wmask = m0_req_wmask;
    if (grant) begin
      sel_wen   = m1_req_wen;
      sel_addr  = m1_req_addr;
      sel_wdata = m1_req_wdata;
      sel_wmask = m1_req_wmask;
    end
  end

  assign owner_resp_ready = owner_q ? m1_resp_ready : m0_resp_ready;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      // NOTE: the wide data buffers are reset too, so every output is defined the instant RST_N falls.
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      wen_q        <= 1'b0;
      rdata_q      <= '0;
      resp_valid_q <= '0;
      sram_cen_q   <= 1'b1;
      sram_wen_q   <= 1'b1;
      sram_bwen_q  <= '1;
      sram_a_q     <= '0;
      sram_d_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (handshake) begin
          owner_q      <= grant;
          last_grant_q <= grant;
          wen_q        <= sel_wen;
          sram_cen_q   <= 1'b0;
          sram_wen_q   <= ~sel_wen;
          sram_bwen_q  <= sel_wen ? ~sel_wmask : '1;
          sram_a_q     <= sel_addr;
          sram_d_q     <= sel_wdata;
          state_q      <= ACCESS;
        end
        ACCESS: begin
          sram_cen_q  <= 1'b1;
          sram_wen_q  <= 1'b1;
          sram_bwen_q <= '1;
          sram_a_q    <= '0;
          sram_d_q    <= '0;
          state_q     <= CAPTURE;
        end
        CAPTURE: begin
          rdata_q      <= wen_q ? '0 : sram_Q;
          resp_valid_q <= owner_q ? 2'b10 : 2'b01;
          state_q      <= RESP;
        end
        RESP: if (owner_resp_ready) begin
          resp_valid_q <= '0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m0_resp_valid = resp_valid_q[0];
  assign m1_resp_valid = resp_valid_q[1];
  assign m0_resp_rdata = resp_valid_q[0] ? rdata_q : '0;
  assign m1_resp_rdata = resp_valid_q[1] ? rdata_q : '0;

  assign sram_CEN  = sram_cen_q;
  assign sram_WEN  = sram_wen_q;
  assign sram_BWEN = sram_bwen_q;
  assign sram_A    = sram_a_q;
  assign sram_D    = sram_d_q;

endmodule

// File: tb/tb_ysyx_22041461_sram_arb.sv
// Bench for ysyx_22041461_sram_arb: directed scenarios plus random traffic, checked
// cycle by cycle against a transaction-timeline model and a reference memory.
module tb_ysyx_22041461_sram_arb;

  localparam int BITS = 128;
  localparam int AW   = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            v[2], w[2], rr[2];
  logic [AW-1:0]   a[2];
  logic [BITS-1:0] d[2], m[2];

  logic            m0_rdy, m1_rdy, m0_rv, m1_rv;
  logic [BITS-1:0] m0_rd, m1_rd;
  logic            sram_cen, sram_wen;
  logic [BITS-1:0] sram_bwen, sram_d, sram_q;
  logic [AW-1:0]   sram_a;

  ysyx_22041461_sram_arb #(.Bits(BITS), .Add_Width(AW)) dut (
    .CLK(clk), .RST_N(rst_n),
    .m0_req_valid(v[0]), .m0_req_ready(m0_rdy), .m0_req_wen(w[0]), .m0_req_addr(a[0]),
    .m0_req_wdata(d[0]), .m0_req_wmask(m[0]), .m0_resp_valid(m0_rv),
    .m0_resp_ready(rr[0]), .m0_resp_rdata(m0_rd),
    .m1_req_valid(v[1]), .m1_req_ready(m1_rdy), .m1_req_wen(w[1]), .m1_req_addr(a[1]),
    .m1_req_wdata(d[1]), .m1_req_wmask(m[1]), .m1_resp_valid(m1_rv),
    .m1_resp_ready(rr[1]), .m1_resp_rdata(m1_rd),
    .sram_CEN(sram_cen), .sram_WEN(sram_wen), .sram_BWEN(sram_bwen),
    .sram_A(sram_a), .sram_D(sram_d), .sram_Q(sram_q)
  );

  // Behavioural SRAM: one-cycle read latency, active-low bit write enables.
  logic [BITS-1:0] sram_mem[2**AW];
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_wen) sram_mem[sram_a] <= (sram_mem[sram_a] & sram_bwen) | (sram_d & ~sram_bwen);
      else           sram_q <= sram_mem[sram_a];
    end
  end

  // Reference model: timeline of the single in-flight transaction plus expected memory.
  logic [BITS-1:0] ref_mem[2**AW];
  bit              busy, owner, last_g, x_wen;
  int              t_hs, cyc;
  logic [AW-1:0]   x_addr;
  logic [BITS-1:0] x_wdata, x_wmask, x_rdata, last_resp;
  bit              hs_now, win_now, rv_obs;
  int              cen_lo_cnt;
  int              grants_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [BITS-1:0] obs, input logic [BITS-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs are already applied; check outputs, advance the model, move to next negedge.
  task automatic step();
    bit              idle, win, hs, acc, rvx, e_cen, e_wen;
    logic [BITS-1:0] e_bwen, e_d;
    logic [AW-1:0]   e_a;
    #1;
    idle = !busy;
    if (v[0] && v[1]) win = !last_g;
    else              win = v[1];
    hs  = idle && (v[0] || v[1]);
    acc = busy && (cyc == t_hs + 1);
    rvx = busy && (cyc >= t_hs + 3);
    e_cen  = !acc;
    e_wen  = acc ? !x_wen : 1'b1;
    e_bwen = (acc && x_wen) ? ~x_wmask : '1;
    e_a    = acc ? x_addr : '0;
    e_d    = acc ? x_wdata : '0;
    check("m0_req_ready", m0_rdy, hs && !win);
    check("m1_req_ready", m1_rdy, hs && win);
    check("sram_CEN", sram_cen, e_cen);
    check("sram_WEN", sram_wen, e_wen);
    check("sram_BWEN", sram_bwen, e_bwen);
    check("sram_A", sram_a, e_a);
    check("sram_D", sram_d, e_d);
    check("m0_resp_valid", m0_rv, rvx && !owner);
    check("m1_resp_valid", m1_rv, rvx && owner);
    if (rvx) check(owner ? "m1_resp_rdata" : "m0_resp_rdata", owner ? m1_rd : m0_rd, x_rdata);
    if (m0_rdy) grants_q.push_back(0);
    if (m1_rdy) grants_q.push_back(1);
    if (!sram_cen) cen_lo_cnt++;
    rv_obs = m0_rv || m1_rv;
    // Effects of the coming rising edge.
    if (acc && x_wen) ref_mem[x_addr] = (ref_mem[x_addr] & ~x_wmask) | (x_wdata & x_wmask);
    if (rvx && rr[owner]) begin
      busy = 1'b0;
      last_resp = owner ? m1_rd : m0_rd;
    end
    if (hs) begin
      busy = 1'b1; t_hs = cyc; owner = win; last_g = win;
      x_wen = w[win]; x_addr = a[win]; x_wdata = d[win]; x_wmask = m[win];
      x_rdata = w[win] ? '0 : ref_mem[a[win]];
    end
    hs_now = hs; win_now = win;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_m0_req_ready", m0_rdy, 1'b0);
    check("rst_m1_req_ready", m1_rdy, 1'b0);
    check("rst_m0_resp_valid", m0_rv, 1'b0);
    check("rst_m1_resp_valid", m1_rv, 1'b0);
    check("rst_m0_resp_rdata", m0_rd, '0);
    check("rst_sram_CEN", sram_cen, 1'b1);
    check("rst_sram_WEN", sram_wen, 1'b1);
    check("rst_sram_BWEN", sram_bwen, '1);
    check("rst_sram_A", sram_a, '0);
    check("rst_sram_D", sram_d, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    busy = 1'b0; last_g = 1'b1;
  endtask

  task automatic scramble(input int i);
    w[i] = 1'($urandom);
    a[i] = AW'($urandom);
    d[i] = {$urandom, $urandom, $urandom, $urandom};
    m[i] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Issue one request from requester i, hold its resp_ready low for `hold` RESP cycles, wait for completion.
  task automatic run_txn(input int i, input bit wen, input logic [AW-1:0] addr,
                         input logic [BITS-1:0] wdata, input logic [BITS-1:0] wmask,
                         input int hold, output int lat);
    bit done;
    int held, k;
    v[i] = 1'b1; w[i] = wen; a[i] = addr; d[i] = wdata; m[i] = wmask;
    rr[i] = (hold == 0);
    cen_lo_cnt = 0;
    done = 1'b0;
    for (k = 0; k < 20 && !done; k++) begin
      step();
      done = hs_now && (win_now == i[0]);
    end
    check("handshake_seen", done, 1'b1);
    v[i] = 1'b0;
    scramble(i);
    lat = -1; held = 0; k = 0;
    while (busy && k < 40) begin
      step();
      k++;
      if (rv_obs) begin
        if (lat < 0) lat = k;
        if (held < hold) held++;
        if (held >= hold) rr[i] = 1'b1;
      end
    end
    check("txn_completes", busy, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [BITS-1:0] x9;
    for (int i = 0; i < 2**AW; i++) begin
      sram_mem[i] = '0;
      ref_mem[i]  = '0;
    end
    for (int i = 0; i < 2; i++) begin
      v[i] = 1'b0; rr[i] = 1'b0; scramble(i);
    end
    v[0] = 1'b1;
    cyc = 0; busy = 1'b0; last_g = 1'b1;
    @(negedge clk);
    do_reset();

    // Contention: both valid continuously, always consumed -> m0, m1, m0, m1.
    grants_q.delete();
    v[0] = 1'b1; v[1] = 1'b1; rr[0] = 1'b1; rr[1] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (hs_now) scramble(win_now);
    end
    v[0] = 1'b0; v[1] = 1'b0;
    for (int k = 0; k < 10 && busy; k++) step();
    check("contention_grant_count", grants_q.size() >= 4, 1'b1);
    for (int k = 0; k < 4 && k < grants_q.size(); k++)
      check($sformatf("contention_grant_%0d", k), grants_q[k], k % 2);

    // Write then read back addr 5.
    run_txn(0, 1'b1, 6'd5, {16{8'hA5}}, '1, 0, lat);
    check("write_cen_low_cycles", cen_lo_cnt, 1);
    check("write_latency", lat, 3);
    check("write_resp_rdata", last_resp, '0);
    run_txn(0, 1'b0, 6'd5, '0, '0, 0, lat);
    check("read_latency", lat, 3);
    check("read_rdata", last_resp, {16{8'hA5}});

    // Partial write of the low byte.
    run_txn(1, 1'b1, 6'd5, '0, {{(BITS-8){1'b0}}, 8'hFF}, 0, lat);
    run_txn(0, 1'b0, 6'd5, '0, '0, 0, lat);
    check("partial_rdata", last_resp, {{15{8'hA5}}, 8'h00});

    // Boundary addresses.
    run_txn(1, 1'b1, 6'd63, {4{32'hDEADBEEF}}, '1, 0, lat);
    run_txn(0, 1'b0, 6'd63, '0, '0, 0, lat);
    check("addr63_rdata", last_resp, {4{32'hDEADBEEF}});

    // Backpressure: m1 holds resp_ready low for 5 RESP cycles while m0 waits.
    v[0] = 1'b1; w[0] = 1'b0; a[0] = 6'd5;
    run_txn(1, 1'b0, 6'd5, '0, '0, 5, lat);
    check("bp_latency", lat, 3);
    check("bp_rdata", last_resp, {{15{8'hA5}}, 8'h00});
    run_txn(0, 1'b0, 6'd5, '0, '0, 0, lat);

    // Reset during the ACCESS cycle of a write to addr 9.
    x9 = {4{32'h12345678}};
    run_txn(0, 1'b1, 6'd9, x9, '1, 0, lat);
    v[0] = 1'b1; w[0] = 1'b1; a[0] = 6'd9; d[0] = {4{32'hFFFF0000}}; m[0] = '1; rr[0] = 1'b1;
    step();
    v[0] = 1'b0;
    do_reset();
    for (int k = 0; k < 4; k++) step();
    run_txn(1, 1'b0, 6'd9, '0, '0, 0, lat);
    check("reset_write_dropped", last_resp, x9);

    // Random traffic.
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (!v[i] && $urandom_range(0, 2) == 0) begin
          v[i] = 1'b1;
          scramble(i);
          a[i] = ($urandom_range(0, 9) == 0) ? 6'd63 : AW'($urandom_range(0, 7));
          if ($urandom_range(0, 2) == 0) m[i] = '1;
        end
        rr[i] = 1'($urandom);
      end
      step();
      if (hs_now) begin
        v[win_now] = 1'b0;
        scramble(win_now);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
